frost32_mem_responder: RTL and testbench

Memory-side responder for the Frost32 CPU data port. It accepts the CPU's request bundle: req_mem_access, addr, data, access type and access size. It services the request against an internal word-organised RAM after a fixed, parameterised latency. It drives the CPU's input bundle: the read data, and wait_for_mem, which stalls the CPU's memory-access stage. It sits between the CPU core and on-chip memory in the top-level test and synthesis wrappers.

---
 rtl/frost32_mem_responder.sv | 149 ++++++++++++++
 tb/tb_frost32_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_responder.sv
// Frost32 data-port memory responder: word RAM serviced after a fixed LATENCY.
// Optional FROST32_MEM_RESPONDER_ERR_EN adds bad_access and blocks misaligned/DiasBad accesses.
module frost32_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        access_type,
  input  logic [1:0]  access_size,
  output logic [31:0] data_out,
  output logic        wait_for_mem
`ifdef FROST32_MEM_RESPONDER_ERR_EN
  , output logic      bad_access
`endif
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;
  typedef enum logic [1:0] {Dias32, Dias16, Dias8, DiasBad} size_t;

  state_t        state, next_state;
  logic [CW-1:0] counter;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic          write_q;
  size_t         size_q;

  logic [31:0]   ram [DEPTH_WORDS];

  logic          enter_done;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_data;
  logic          cur_write;
  size_t         cur_size;
  size_t         eff_size;
  logic [1:0]    lane;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rdata;

  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      counter <= '0;
    end else begin
      state <= next_state;
      case (state)
        StIdle: if (req_mem_access) begin
          addr_q  <= addr[AW+1:0];
          data_q  <= data_in;
          write_q <= access_type;
          size_q  <= size_t'(access_size);
          counter <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
        end
        StBusy: if (counter != '0) counter <= counter - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      StIdle:  if (req_mem_access) next_state = (LATENCY == 1) ? StDone : StBusy;
      StBusy:  if (counter == '0) next_state = StDone;
      StDone:  next_state = StIdle;
      default: next_state = StIdle;
    endcase
  end

  always_comb begin
    wait_for_mem = (state == StIdle && req_mem_access) || state == StBusy;
    enter_done   = rst_n && next_state == StDone && state != StDone;
  end

  // With LATENCY == 1 the commit edge is also the latch edge, so use live inputs from StIdle.
  always_comb begin
    cur_addr  = (state == StIdle) ? addr[AW+1:0] : addr_q;
    cur_data  = (state == StIdle) ? data_in : data_q;
    cur_write = (state == StIdle) ? access_type : write_q;
    cur_size  = (state == StIdle) ? size_t'(access_size) : size_q;
  end

  assign rd_word = ram[cur_addr[AW+1:2]];

  always_comb begin
    eff_size = cur_size;
    lane     = cur_addr[1:0];
    bad      = 1'b0;
`ifdef FROST32_MEM_RESPONDER_ERR_EN
    bad = (cur_size == DiasBad) ||
          (cur_size == Dias32 && cur_addr[1:0] != 2'b00) ||
          (cur_size == Dias16 && cur_addr[0]);
`else
    if (eff_size == DiasBad) eff_size = Dias32;
`endif
    case (eff_size)
      Dias16: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{cur_data[15:0]}};
        rdata = {16'h0000, lane[1] ? rd_word[31:16] : rd_word[15:0]};
      end
      Dias8: begin
        be    = 4'b0001 << lane;
        wdata = {4{cur_data[7:0]}};
        rdata = {24'h000000, rd_word[{lane, 3'b000} +: 8]};
      end
      default: begin
        be    = 4'hF;
        wdata = cur_data;
        rdata = rd_word;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (enter_done && cur_write && !bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram[cur_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (enter_done && !cur_write) begin
      data_out <= bad ? '0 : rdata;
    end
  end

`ifdef FROST32_MEM_RESPONDER_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bad_access <= 1'b0;
    else        bad_access <= enter_done && bad;
  end
`endif

endmodule

// File: tb/tb_frost32_mem_responder.sv
// Scoreboard bench for frost32_mem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_frost32_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        at = 1'b0;
  logic [1:0]  sz = '0;
  logic [31:0] data_out;
  logic        wait_for_mem;
  logic        bad_obs;

  int asserts = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  bit [7:0] mdl [int];

  frost32_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_mem_access(req), .addr(addr), .data_in(din),
    .access_type(at), .access_size(sz), .data_out(data_out), .wait_for_mem(wait_for_mem)
`ifdef FROST32_MEM_RESPONDER_ERR_EN
    , .bad_access(bad_obs)
`endif
  );
`ifndef FROST32_MEM_RESPONDER_ERR_EN
  assign bad_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic do_req(input bit wr, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d,
                        output int lat, output logic [31:0] dout, output logic bad);
    @(posedge clk); #1;
    req = 1'b1; at = wr; sz = s; addr = a; din = d;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (!wait_for_mem) break;
      lat++;
      if (lat > 50) begin lat = -1; break; end
    end
    dout = data_out;
    bad = bad_obs;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  function automatic void m_write(bit [1:0] s, bit [31:0] a, bit [31:0] d);
    int n = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    for (int i = 0; i < n; i++) mdl[int'((a + i) & 32'hFFF)] = d[8*i +: 8];
  endfunction

  function automatic bit [31:0] m_read(bit [1:0] s, bit [31:0] a);
    bit [31:0] r = '0;
    int n = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      int k = int'((a + i) & 32'hFFF);
      r[8*i +: 8] = mdl.exists(k) ? mdl[k] : 8'h00;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      asserts++;
      if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
      asserts++;
      if (wait_for_mem !== 1'b0) begin fails++; $display("FAIL reset_wait: got %b expected 0", wait_for_mem); end
    end
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    do_req(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, lat, d, b);
    asserts++;
    if (lat !== LAT) begin fails++; $display("FAIL word_write_latency: got %0d expected %0d", lat, LAT); end
    exp_q.push_back(32'hDEADBEEF);
    do_req(1'b0, 2'd0, 32'h10, 32'h0, lat, d, b);
    e = exp_q.pop_front();
    asserts++;
    if (d !== e) begin fails++; $display("FAIL word_read: got %h expected %h", d, e); end
    asserts++;
    if (lat !== LAT) begin fails++; $display("FAIL word_read_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    logic [1:0]  rs [4] = '{2'd0, 2'd2, 2'd1, 2'd2};
    logic [31:0] ra [4] = '{32'h20, 32'h23, 32'h22, 32'h21};
    do_req(1'b1, 2'd0, 32'h20, 32'h0, lat, d, b);
    do_req(1'b1, 2'd2, 32'h23, 32'hFFFFFFAB, lat, d, b);
    do_req(1'b1, 2'd1, 32'h20, 32'hFFFF1234, lat, d, b);
    exp_q.push_back(32'hAB001234);
    exp_q.push_back(32'h000000AB);
    exp_q.push_back(32'h0000AB00);
    exp_q.push_back(32'h00000012);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, rs[i], ra[i], 32'h0, lat, d, b);
      e = exp_q.pop_front();
      asserts++;
      if (d !== e) begin fails++; $display("FAIL subword_read_%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    do_req(1'b1, 2'd0, 32'h1000, 32'h11111111, lat, d, b);
    exp_q.push_back(32'h11111111);
    do_req(1'b0, 2'd0, 32'h0, 32'h0, lat, d, b);
    e = exp_q.pop_front();
    asserts++;
    if (d !== e) begin fails++; $display("FAIL addr_wrap: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    do_req(1'b1, 2'd0, 32'h40, 32'h5, lat, d, b);
    @(posedge clk); #1;
    req = 1'b1; at = 1'b1; sz = 2'd0; addr = 32'h40; din = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    asserts++;
    if (wait_for_mem !== 1'b0) begin fails++; $display("FAIL reset_mid_wait: got %b expected 0", wait_for_mem); end
    asserts++;
    if (data_out !== 32'h0) begin fails++; $display("FAIL reset_mid_data_out: got %h expected %h", data_out, 32'h0); end
    exp_q.push_back(32'h5);
    do_req(1'b0, 2'd0, 32'h40, 32'h0, lat, d, b);
    e = exp_q.pop_front();
    asserts++;
    if (d !== e) begin fails++; $display("FAIL reset_mid_write_dropped: got %h expected %h", d, e); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    do_req(1'b1, 2'd0, 32'h42, 32'hCAFEF00D, lat, d, b);
    asserts++;
    if (lat !== LAT) begin fails++; $display("FAIL misaligned_latency: got %0d expected %0d", lat, LAT); end
`ifdef FROST32_MEM_RESPONDER_ERR_EN
    asserts++;
    if (b !== 1'b1) begin fails++; $display("FAIL bad_access_pulse: got %b expected 1", b); end
    asserts++;
    if (bad_obs !== 1'b0) begin fails++; $display("FAIL bad_access_width: got %b expected 0", bad_obs); end
    exp_q.push_back(32'h5);
`else
    exp_q.push_back(32'hCAFEF00D);
`endif
    do_req(1'b0, 2'd0, 32'h40, 32'h0, lat, d, b);
    e = exp_q.pop_front();
    asserts++;
    if (d !== e) begin fails++; $display("FAIL misaligned_word: got %h expected %h", d, e); end
    asserts++;
    if (b !== 1'b0) begin fails++; $display("FAIL aligned_bad_access: got %b expected 0", b); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic b; logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      bit [31:0] v = $urandom;
      m_write(2'd0, 32'h400 + 4*i, v);
      do_req(1'b1, 2'd0, 32'h400 + 4*i, v, lat, d, b);
    end
    for (int i = 0; i < 24; i++) begin
      bit [1:0]  s = 2'($urandom_range(0, 2));
      bit [31:0] a = 32'h400 + 4 * $urandom_range(0, 7);
      bit [31:0] v = $urandom;
      if (s == 2'd1) a += 2 * $urandom_range(0, 1);
      if (s == 2'd2) a += $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        m_write(s, a, v);
        do_req(1'b1, s, a, v, lat, d, b);
      end else begin
        exp_q.push_back(m_read(s, a));
        do_req(1'b0, s, a, 32'h0, lat, d, b);
        e = exp_q.pop_front();
        asserts++;
        if (d !== e) begin fails++; $display("FAIL b2b_read_%0d: got %h expected %h (size %0d addr %h)", i, d, e, s, a); end
      end
      asserts++;
      if (lat !== LAT) begin fails++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, lat, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_wrap();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
